// File: rtl/clk_trigger_modulator.sv
// clk_trigger_modulator: programmable divided clock from fastclk.
// The period and high time are set at run time. A synchronized trigger
// selects the duty setting, gates the output or is ignored, depending on mode.
// Configuration and trigger are sampled only at period boundaries, so
// clk_out never produces a runt pulse.
// Optional feature macro: CLKMOD_GATE_EN. When it is defined, mode 10 gates
// whole periods low while the latched trigger is 1. When it is undefined,
// mode 10 behaves exactly like mode 00 and no gate logic is built.
module clk_trigger_modulator #(
  parameter int CNT_W       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             fastclk,
  input  logic             reset_n,
  input  logic             trigger,
  input  logic [CNT_W-1:0] div_n,
  input  logic [CNT_W-1:0] hi_idle,
  input  logic [CNT_W-1:0] hi_trig,
  input  logic [1:0]       mode,
  input  logic             cfg_load,
  output logic             cfg_ack,
  output logic             clk_out,
  output logic             period_start,
  output logic             trig_sync
);

  localparam logic [CNT_W-1:0] C_P_RST  = CNT_W'(4);
  localparam logic [CNT_W-1:0] C_HI_RST = CNT_W'(3);
  localparam logic [CNT_W-1:0] C_HT_RST = CNT_W'(1);
  localparam logic [CNT_W-1:0] C_P_MIN  = CNT_W'(2);
  localparam logic [1:0]       C_M_OFF  = 2'b11;

  logic [SYNC_STAGES-1:0] r_sync;

  // Active configuration
  logic [CNT_W-1:0] r_p, r_hi_idle, r_hi_trig;
  logic [1:0]       r_mode;
  // Shadow configuration
  logic [CNT_W-1:0] r_sh_p, r_sh_hi_idle, r_sh_hi_trig;
  logic [1:0]       r_sh_mode;
  logic             r_pending;

  logic [CNT_W-1:0] r_cnt, r_h_cur;
  logic             r_clk_out, r_period_start, r_cfg_ack;

  logic [CNT_W-1:0] w_div_clamped;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_boundary, w_off, w_apply;
  logic [CNT_W-1:0] w_p_new, w_hi_idle_new, w_hi_trig_new;
  logic [1:0]       w_mode_new, w_mode_dec;
  logic [CNT_W-1:0] w_h_sel;
  logic [CNT_W-1:0] w_cnt_next, w_h_cur_next;
  logic             w_clk_next, w_ps_next, w_pending_next;

  assign w_div_clamped = (div_n < C_P_MIN) ? C_P_MIN : div_n;

  assign trig_sync    = r_sync[SYNC_STAGES-1];
  assign clk_out      = r_clk_out;
  assign period_start = r_period_start;
  assign cfg_ack      = r_cfg_ack;

  // Trigger synchronizer chain
  always_ff @(posedge fastclk or negedge reset_n) begin
    if (!reset_n) r_sync <= '0;
    else          r_sync <= {r_sync[SYNC_STAGES-2:0], trigger};
  end

  // Boundary detection, config application and next-period decode
  always_comb begin
    w_cnt_inc  = r_cnt + CNT_W'(1);
    w_boundary = (r_cnt == (r_p - CNT_W'(1)));
    // Off mode treats every edge as a config boundary, but the counter stays parked
    w_off      = (r_mode == C_M_OFF);
    w_apply    = r_pending && (w_boundary || w_off);

    if (w_apply) begin
      w_p_new       = r_sh_p;
      w_hi_idle_new = r_sh_hi_idle;
      w_hi_trig_new = r_sh_hi_trig;
      w_mode_new    = r_sh_mode;
    end else begin
      w_p_new       = r_p;
      w_hi_idle_new = r_hi_idle;
      w_hi_trig_new = r_hi_trig;
      w_mode_new    = r_mode;
    end

`ifdef CLKMOD_GATE_EN
    w_mode_dec = w_mode_new;
`else
    w_mode_dec = (w_mode_new == 2'b10) ? 2'b00 : w_mode_new;
`endif

    w_h_sel = w_hi_idle_new;
    case (w_mode_dec)
      2'b00:   w_h_sel = trig_sync ? w_hi_trig_new : w_hi_idle_new;
`ifdef CLKMOD_GATE_EN
      2'b10:   w_h_sel = trig_sync ? '0 : w_hi_idle_new;
`endif
      default: w_h_sel = w_hi_idle_new;
    endcase

    w_cnt_next   = w_cnt_inc;
    w_h_cur_next = r_h_cur;
    w_clk_next   = (w_cnt_inc < r_h_cur);
    w_ps_next    = 1'b0;

    // Parking at P-1 makes the first edge after leaving off mode a true boundary
    if (w_off || (w_boundary && (w_mode_new == C_M_OFF))) begin
      w_cnt_next   = w_p_new - CNT_W'(1);
      w_h_cur_next = '0;
      w_clk_next   = 1'b0;
    end else if (w_boundary) begin
      w_cnt_next   = '0;
      w_h_cur_next = w_h_sel;
      w_clk_next   = (w_h_sel != '0);
      w_ps_next    = 1'b1;
    end

    // A load on the applying edge re-arms pending for the following boundary
    w_pending_next = cfg_load ? 1'b1 : (w_apply ? 1'b0 : r_pending);
  end

  // Shadow capture on cfg_load; the last load before a boundary wins
  always_ff @(posedge fastclk or negedge reset_n) begin
    if (!reset_n) begin
      r_sh_p       <= C_P_RST;
      r_sh_hi_idle <= C_HI_RST;
      r_sh_hi_trig <= C_HT_RST;
      r_sh_mode    <= 2'b00;
      r_pending    <= 1'b0;
    end else begin
      if (cfg_load) begin
        r_sh_p       <= w_div_clamped;
        r_sh_hi_idle <= hi_idle;
        r_sh_hi_trig <= hi_trig;
        r_sh_mode    <= mode;
      end
      r_pending <= w_pending_next;
    end
  end

  // Active config, period counter and registered outputs
  always_ff @(posedge fastclk or negedge reset_n) begin
    if (!reset_n) begin
      r_p            <= C_P_RST;
      r_hi_idle      <= C_HI_RST;
      r_hi_trig      <= C_HT_RST;
      r_mode         <= 2'b00;
      r_cnt          <= C_P_RST - CNT_W'(1);
      r_h_cur        <= C_HI_RST;
      r_clk_out      <= 1'b0;
      r_period_start <= 1'b0;
      r_cfg_ack      <= 1'b0;
    end else begin
      if (w_apply) begin
        r_p       <= w_p_new;
        r_hi_idle <= w_hi_idle_new;
        r_hi_trig <= w_hi_trig_new;
        r_mode    <= w_mode_new;
      end
      r_cnt          <= w_cnt_next;
      r_h_cur        <= w_h_cur_next;
      r_clk_out      <= w_clk_next;
      r_period_start <= w_ps_next;
      r_cfg_ack      <= w_apply;
    end
  end

endmodule

// File: tb/tb_clk_trigger_modulator.sv
// Directed bench for clk_trigger_modulator with hand-computed output patterns.
// Each pattern string lists one bit per fastclk edge, with the first edge leftmost.
module tb_clk_trigger_modulator;

  logic       fastclk;
  logic       reset_n;
  logic       trigger;
  logic [7:0] div_n, hi_idle, hi_trig;
  logic [1:0] mode;
  logic       cfg_load;
  logic       cfg_ack, clk_out, period_start, trig_sync;

  int checks   = 0;
  int failures = 0;

  logic        g_bit;
  logic [63:0] v_clk;

  clk_trigger_modulator #(.CNT_W(8), .SYNC_STAGES(2)) dut (
    .fastclk      (fastclk),
    .reset_n      (reset_n),
    .trigger      (trigger),
    .div_n        (div_n),
    .hi_idle      (hi_idle),
    .hi_trig      (hi_trig),
    .mode         (mode),
    .cfg_load     (cfg_load),
    .cfg_ack      (cfg_ack),
    .clk_out      (clk_out),
    .period_start (period_start),
    .trig_sync    (trig_sync)
  );

  initial fastclk = 1'b0;
  always #5 fastclk = ~fastclk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Advance n edges; after each one, compare the outputs on the falling edge
  task automatic run(input string tag, input int n,
                     input logic [63:0] e_clk, input logic [63:0] e_ps,
                     input logic [63:0] e_ack);
    for (int i = 0; i < n; i++) begin
      @(posedge fastclk);
      @(negedge fastclk);
      chk($sformatf("%s[%0d].clk_out", tag, i), clk_out, e_clk[n-1-i]);
      chk($sformatf("%s[%0d].period_start", tag, i), period_start, e_ps[n-1-i]);
      chk($sformatf("%s[%0d].cfg_ack", tag, i), cfg_ack, e_ack[n-1-i]);
    end
  endtask

  task automatic load(input logic [7:0] d, input logic [7:0] hi, input logic [7:0] ht,
                      input logic [1:0] m);
    div_n    = d;
    hi_idle  = hi;
    hi_trig  = ht;
    mode     = m;
    cfg_load = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
`ifdef CLKMOD_GATE_EN
    g_bit = 1'b0;
`else
    g_bit = 1'b1;
`endif
    reset_n  = 1'b0;
    trigger  = 1'b0;
    div_n    = 8'd4;
    hi_idle  = 8'd3;
    hi_trig  = 8'd1;
    mode     = 2'b00;
    cfg_load = 1'b0;

    @(negedge fastclk);
    @(negedge fastclk);
    chk("reset.clk_out", clk_out, 1'b0);
    chk("reset.period_start", period_start, 1'b0);
    chk("reset.cfg_ack", cfg_ack, 1'b0);
    chk("reset.trig_sync", trig_sync, 1'b0);
    reset_n = 1'b1;

    // Default 4-phase 75% pattern
    run("idle", 16, 64'b1110_1110_1110_1110, 64'b1000_1000_1000_1000, 64'b0);

    // Trigger rise: two sync edges, the period in flight completes, then 25%
    trigger = 1'b1;
    run("trig_e1", 1, 64'b1, 64'b1, 64'b0);
    chk("trig_sync_lat1", trig_sync, 1'b0);
    run("trig_e2", 1, 64'b1, 64'b0, 64'b0);
    chk("trig_sync_lat2", trig_sync, 1'b1);
    run("trig_run", 10, 64'b10_1000_1000, 64'b00_1000_1000, 64'b0);

    // Trigger fall: resumes 75% at the next boundary
    trigger = 1'b0;
    run("untrig_e1", 1, 64'b1, 64'b1, 64'b0);
    chk("untrig_sync1", trig_sync, 1'b1);
    run("untrig_e2", 1, 64'b0, 64'b0, 64'b0);
    chk("untrig_sync2", trig_sync, 1'b0);
    run("untrig_run", 6, 64'b001110, 64'b001000, 64'b0);

    // Mid-period load of P=10 H=5
    run("c_start", 1, 64'b1, 64'b1, 64'b0);
    load(8'd10, 8'd5, 8'd1, 2'b00);
    run("c_load", 1, 64'b1, 64'b0, 64'b0);
    cfg_load = 1'b0;
    run("c_run", 13, 64'b1_0_11111_00000_1, 64'b0_0_10000_00000_1, 64'b0_0_10000_00000_0);

    // div_n=1 clamps to P=2 with H=0: constant low
    load(8'd1, 8'd0, 8'd1, 2'b00);
    run("d_load", 1, 64'b1, 64'b0, 64'b0);
    cfg_load = 1'b0;
    run("d_run", 14, 64'b111_00000_000000, 64'b000_00000_101010, 64'b000_00000_100000);

    // Load on a boundary edge waits one more period; H=200 >= P=10 gives constant high
    load(8'd10, 8'd200, 8'd1, 2'b00);
    run("e_load", 1, 64'b0, 64'b1, 64'b0);
    cfg_load = 1'b0;
    run("e_run", 13, 64'b0_1_111111111_1_1, 64'b0_1_000000000_1_0, 64'b0_1_000000000_0_0);

    // Mode 10 with trigger held high
    load(8'd4, 8'd3, 8'd1, 2'b10);
    trigger = 1'b1;
    run("f_load", 1, 64'b1, 64'b0, 64'b0);
    cfg_load = 1'b0;
    run("f_e2", 1, 64'b1, 64'b0, 64'b0);
    chk("f_trig_sync", trig_sync, 1'b1);
    v_clk = '0;
    v_clk[10:0] = {6'b111111, g_bit, 3'b000, g_bit};
    run("f_run", 11, v_clk, 64'b000000_1_000_1, 64'b000000_1_000_0);
    trigger = 1'b0;
    run("f_drop", 7, 64'b000_1110, 64'b000_1000, 64'b0);

    // Enter off mode; the load lands on the edge just before a boundary
    run("g_pre", 3, 64'b111, 64'b100, 64'b0);
    load(8'd4, 8'd3, 8'd1, 2'b11);
    run("g_load", 1, 64'b0, 64'b0, 64'b0);
    cfg_load = 1'b0;
    run("g_off", 4, 64'b0000, 64'b0000, 64'b1000);
    // In off mode the ack follows one edge after the load
    load(8'd4, 8'd3, 8'd1, 2'b00);
    run("g_load2", 1, 64'b0, 64'b0, 64'b0);
    cfg_load = 1'b0;
    run("g_exit", 5, 64'b01110, 64'b01000, 64'b10000);

    // Asynchronous reset mid-period with a load pending
    run("h_pre", 2, 64'b11, 64'b10, 64'b0);
    load(8'd10, 8'd5, 8'd1, 2'b00);
    run("h_load", 1, 64'b1, 64'b0, 64'b0);
    cfg_load = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    chk("h_rst.clk_out", clk_out, 1'b0);
    chk("h_rst.period_start", period_start, 1'b0);
    chk("h_rst.cfg_ack", cfg_ack, 1'b0);
    chk("h_rst.trig_sync", trig_sync, 1'b0);
    @(negedge fastclk);
    @(negedge fastclk);
    reset_n = 1'b1;
    run("h_resume", 8, 64'b1110_1110, 64'b1000_1000, 64'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/clk_trigger_modulator.md
# clk_trigger_modulator

Parametrised trigger-modulated clock generator: derives a divided clock from `fastclk` whose period and high time are run-time programmable, with an asynchronous `trigger` selecting between two duty settings, gating the output, or being ignored according to `mode`. Configuration and trigger are applied only at period boundaries, so `clk_out` never glitches or produces a runt pulse. It is the next-generation replacement for the fixed divide-by-2 and fixed 4-phase trigger/clock combiners. Its reset defaults reproduce the 4-phase 75%/25% behaviour.

## Interface
- `CNT_W`, 8: width of the period counter and of all config fields.
- `SYNC_STAGES`, 2: trigger synchronizer depth; minimum 2.
- `fastclk` in 1: sole clock; all logic is on the rising edge.
- `reset_n` in 1: reset is asynchronous and active-low.
- `trigger` in 1: asynchronous modulation request.
- `div_n` in CNT_W: requested period in `fastclk` cycles; values 0 and 1 are clamped to 2.
- `hi_idle` in CNT_W: high cycles per period when the latched trigger is 0.
- `hi_trig` in CNT_W: high cycles per period when the latched trigger is 1.
- `mode` in 2: 00 duty-modulate, 01 divide-only, 10 gate, 11 off.
- `cfg_load` in 1: a one-cycle pulse that captures `div_n`, `hi_idle`, `hi_trig` and `mode` into shadow registers.
- `cfg_ack` out 1: one-cycle pulse when the shadowed configuration becomes active.
- `clk_out` out 1: registered modulated clock.
- `period_start` out 1: one-cycle pulse coincident with the first cycle of each period.
- `trig_sync` out 1: synchronized trigger, i.e. the last synchronizer stage.

## Operation
- Trigger synchronizer: a chain of SYNC_STAGES flops clocked on `fastclk`; all stages reset to 0.
- Register sets:
  - Active registers: P, H_idle, H_trig, M.
  - Shadow registers: same fields, plus a `pending` flag.
  - `cfg_load` at an edge sets `pending` and overwrites the shadows; the last load wins.
- Counter `cnt`, range 0..P-1:
  - The edge where `cnt == P-1` is a *boundary edge*; otherwise `cnt` increments.
  - At a boundary edge: `cnt` goes to 0.
  - If `pending` was set before this edge, the shadows are copied to active, `pending` clears and `cfg_ack` pulses.
  - A `cfg_load` coinciding with the boundary edge takes effect at the following boundary.
  - Period high count H_cur is latched at the boundary, using the new config if applied and `trig_sync` as sampled at that edge:
    - mode 00: `trig_sync ? H_trig : H_idle`
    - mode 01: `H_idle`
    - mode 10: `trig_sync ? 0 : H_idle`
- Output: `clk_out` is registered, with next value `(cnt_next < H_cur_next)`:
  - H ≥ P gives constant high for that period.
  - H = 0 gives constant low.
  - Comparisons are unsigned in CNT_W bits.
- Mode 11 (off):
  - `cnt` is held at P-1; `clk_out` = 0; `period_start` = 0.
  - Every edge is treated as a boundary for config application only.
  - After leaving off mode, the next edge is a true boundary edge.
- `trigger` changes in the middle of a period never alter the current period.

## Timing
- Reset values:
  - `cnt` = 3; active and shadow registers: P=4, H_idle=3, H_trig=1, M=00.
  - `pending`, `cfg_ack`, `period_start`, `clk_out`, `trig_sync` = 0.
- First edge after `reset_n` rises is a boundary edge.
- Trigger to `trig_sync` latency: SYNC_STAGES edges.
- `trig_sync` to effect on `clk_out`: at most P edges, at the next boundary.
- `cfg_load` to `cfg_ack`:
  - Normally at least 1 edge, at most P edges.
  - In mode 11, exactly 1 edge.
- `period_start` and `cfg_ack` are asserted in the same cycle `clk_out` begins the new period.
- Reset asserted mid-period forces the reset values asynchronously; a pending config is discarded.

## Configuration
- Macro `CLKMOD_GATE_EN`.
- Defined: mode 10 gates whole periods low while `trig_sync` is latched as 1.
- Undefined: mode 10 is decoded as mode 00, and no gate logic is synthesised.

## Test plan
- Reset, then hold `trigger`=0 for 16 edges → `clk_out` pattern 1,1,1,0 repeated; `period_start` every 4th edge.
- Raise `trigger`, then hold → after 2 sync edges plus the next boundary, pattern 1,0,0,0; no short or merged pulse at the switch.
- `cfg_load` mid-period with `div_n`=10, `hi_idle`=5 → current period completes as 4 cycles, `cfg_ack` pulses at the boundary, then 5 high/5 low.
- `div_n`=1, `hi_idle`=0 → P=2 and constant low. `hi_idle`=200 with `div_n`=10 → constant high, with `period_start` every 2 and every 10 edges respectively.
- Mode 10 with `trigger`=1:
  - With `CLKMOD_GATE_EN`: `clk_out` is 0 for whole periods.
  - Without it: pattern 1,0,0,0.
  - Dropping `trigger` resumes 1,1,1,0 at a boundary.
- Mode 11 via `cfg_load` → `cfg_ack` next edge and `clk_out` 0. Assert `reset_n`=0 mid-period with a pending load → outputs reset, and defaults resume after release.
